// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page with a debug FIFO and
// an optional cycle timer with compare IRQ, present only when DATA_MEM_TIMER_EN is defined.
module data_mem_responder #(
    parameter int RAM_AW  = 6,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready,
    output logic        irq
);
    localparam int RAM_DEPTH  = 1 << RAM_AW;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic              is_mmio;
    logic [1:0]        off;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_cmp, wr_stat, wr_push;

    assign is_mmio = (addr[31:16] == 16'hFFFF);
    assign off     = addr[3:2];
    assign ram_idx = addr[RAM_AW+1:2];
    assign wr_cmp  = memwrite & is_mmio & (off == 2'd1);
    assign wr_stat = memwrite & is_mmio & (off == 2'd2);
    assign wr_push = memwrite & is_mmio & (off == 2'd3);

    logic unused_addr;
    assign unused_addr = ^{addr[15:4], addr[1:0]};

    // RAM is deliberately outside the reset domain so contents survive reset.
    logic [31:0] mem [RAM_DEPTH];
    always_ff @(posedge clk) begin
        if (memwrite && !is_mmio) mem[ram_idx] <= writedata;
    end

    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               full, empty, pop, push;

    assign full      = (count_q == FIFO_FULL);
    assign empty     = (count_q == '0);
    assign pop       = !empty & dbg_ready;
    // A pop frees the head slot this cycle, so a push into a full FIFO still fits.
    assign push      = wr_push & (!full | pop);
    assign dbg_valid = !empty;
    assign dbg_data  = empty ? '0 : fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = (wr_push & full & !pop) | (ovf_q & ~(wr_stat & writedata[3]));
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    logic [31:0] cycle_rd, cmp_rd;
    logic        irq_pend;

`ifdef DATA_MEM_TIMER_EN
    logic [31:0] cycle_q, cycle_d, cmp_q, cmp_d;
    logic        irq_pend_q, irq_pend_d;

    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        cmp_d      = wr_cmp ? writedata : cmp_q;
        // Match takes priority over a same-cycle W1C so no event is lost.
        irq_pend_d = (cycle_q == cmp_q) | (irq_pend_q & ~(wr_stat & writedata[2]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q    <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            irq_pend_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            cmp_q      <= cmp_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign cycle_rd = cycle_q;
    assign cmp_rd   = cmp_q;
    assign irq_pend = irq_pend_q;
`else
    logic unused_timer;
    assign unused_timer = wr_cmp;
    assign cycle_rd     = '0;
    assign cmp_rd       = '0;
    assign irq_pend     = 1'b0;
`endif

    assign irq = irq_pend;

    logic [31:0] mmio_rd;
    always_comb begin
        mmio_rd = '0;
        case (off)
            2'd0:    mmio_rd = cycle_rd;
            2'd1:    mmio_rd = cmp_rd;
            2'd2:    mmio_rd = {28'd0, ovf_q, irq_pend, empty, full};
            default: mmio_rd = '0;
        endcase
        readdata = is_mmio ? mmio_rd : mem[ram_idx];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: queue/array reference model checked every cycle plus literal checks.
module tb_data_mem_responder;
`ifdef DATA_MEM_TIMER_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif
    localparam int RAM_AW = 6;
    localparam int DEPTH  = 8;
    localparam logic [31:0] CYC  = 32'hFFFF_0000;
    localparam logic [31:0] CMP  = 32'hFFFF_0004;
    localparam logic [31:0] STAT = 32'hFFFF_0008;
    localparam logic [31:0] PUSH = 32'hFFFF_000C;

    logic        clk = 1'b0, reset = 1'b1, memwrite = 1'b0, dbg_ready = 1'b0;
    logic [31:0] addr = '0, writedata = '0;
    logic [31:0] readdata, dbg_data;
    logic        dbg_valid, irq;

    always #5 clk = ~clk;

    data_mem_responder #(.RAM_AW(RAM_AW), .FIFO_AW(3)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
        .readdata(readdata), .dbg_data(dbg_data), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .irq(irq)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue for the FIFO, associative array for RAM.
    logic [31:0] m_ram [int];
    logic [31:0] m_q [$];
    logic [31:0] m_cyc = '0, m_cmp = '1;
    bit          m_irq = 1'b0, m_ovf = 1'b0;
    bit          mm, m_pop, m_full, m_match;
    logic [1:0]  m_off;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_q.delete();
            m_cyc = '0; m_cmp = '1; m_irq = 1'b0; m_ovf = 1'b0;
        end else begin
            mm      = (addr[31:16] == 16'hFFFF);
            m_off   = addr[3:2];
            m_pop   = (m_q.size() > 0) && dbg_ready;
            m_full  = (m_q.size() == DEPTH);
            m_match = TEN && (m_cyc == m_cmp);
            if (m_pop) void'(m_q.pop_front());
            if (memwrite && !mm) m_ram[int'(addr[RAM_AW+1:2])] = writedata;
            if (memwrite && mm) begin
                case (m_off)
                    2'd1: if (TEN) m_cmp = writedata;
                    2'd2: begin
                        if (writedata[2]) m_irq = 1'b0;
                        if (writedata[3]) m_ovf = 1'b0;
                    end
                    2'd3: if (m_full && !m_pop) m_ovf = 1'b1; else m_q.push_back(writedata);
                    default: ;
                endcase
            end
            if (m_match) m_irq = 1'b1;
            m_cyc = m_cyc + 32'd1;
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a[31:16] == 16'hFFFF) begin
            case (a[3:2])
                2'd0:    return TEN ? m_cyc : 32'd0;
                2'd1:    return TEN ? m_cmp : 32'd0;
                2'd2:    return {28'd0, m_ovf, TEN & m_irq, m_q.size() == 0, m_q.size() == DEPTH};
                default: return 32'd0;
            endcase
        end
        if (m_ram.exists(int'(a[RAM_AW+1:2]))) return m_ram[int'(a[RAM_AW+1:2])];
        known = 1'b0;
        return 32'd0;
    endfunction

    logic [31:0] c_exp;
    bit          c_known;
    initial forever begin
        @(negedge clk);
        c_exp = m_read(addr, c_known);
        if (c_known) chk("mdl_readdata", readdata, c_exp);
        chk("mdl_valid", dbg_valid, (m_q.size() != 0));
        chk("mdl_data", dbg_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
        chk("mdl_irq", irq, TEN & m_irq);
    end

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        memwrite = mw; addr = a; writedata = wd; dbg_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a);
        memwrite = 1'b0; addr = a;
        #1;
    endtask

    task automatic wait_cyc(input logic [31:0] t);
        for (int k = 0; k < 60; k++) begin
            peek(CYC);
            if (readdata == t) break;
            step(1'b0, CYC, 32'd0, dbg_ready);
        end
        peek(CYC);
        chk("wait_cyc", readdata, t);
    endtask

    logic [31:0] c;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        peek(STAT); chk("rst_status", readdata, 32'h2);
        chk("rst_valid", dbg_valid, 32'd0);
        chk("rst_irq", irq, 32'd0);
        peek(CMP);  chk("rst_cmp", readdata, TEN ? 32'hFFFF_FFFF : 32'd0);

        // RAM store, alias, read-during-write
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        peek(32'h10);  chk("ram_rd", readdata, 32'hDEAD_BEEF);
        peek(32'h110); chk("ram_alias", readdata, 32'hDEAD_BEEF);
        memwrite = 1'b1; addr = 32'h10; writedata = 32'h1111_1111;
        #1 chk("ram_rdw_old", readdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        peek(32'h10); chk("ram_rdw_new", readdata, 32'h1111_1111);

        // FIFO overfill, W1C ovf, drain
        for (int i = 1; i <= 9; i++) step(1'b1, PUSH, i, 1'b0);
        peek(STAT); chk("fill_status", readdata, 32'h9);
        chk("fill_head", dbg_data, 32'd1);
        step(1'b1, STAT, 32'h8, 1'b0);
        peek(STAT); chk("ovf_clr_status", readdata, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", dbg_data, i);
            step(1'b0, 32'h0, 32'd0, 1'b1);
        end
        chk("drain_valid", dbg_valid, 32'd0);
        peek(STAT); chk("drain_status", readdata, 32'h2);

        // push+pop while full
        for (int i = 1; i <= 8; i++) step(1'b1, PUSH, 32'h100 + i, 1'b0);
        step(1'b1, PUSH, 32'hAA, 1'b1);
        peek(STAT); chk("fullpp_status", readdata, 32'h1);
        for (int i = 2; i <= 8; i++) begin
            chk("fullpp_data", dbg_data, 32'h100 + i);
            step(1'b0, 32'h0, 32'd0, 1'b1);
        end
        chk("fullpp_last", dbg_data, 32'hAA);
        step(1'b0, 32'h0, 32'd0, 1'b1);
        chk("fullpp_empty", dbg_valid, 32'd0);

        if (TEN) begin
            #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            step(1'b1, CMP, 32'd20, 1'b0);
            wait_cyc(32'd20);
            chk("irq_pre", irq, 32'd0);
            step(1'b0, CYC, 32'd0, 1'b0);
            peek(CYC); chk("cyc_21", readdata, 32'd21);
            chk("irq_set", irq, 32'd1);
            step(1'b1, STAT, 32'h4, 1'b0);
            chk("irq_w1c", irq, 32'd0);
            peek(CYC); c = readdata;
            step(1'b1, CMP, c + 32'd5, 1'b0);
            wait_cyc(c + 32'd5);
            step(1'b1, STAT, 32'h4, 1'b0);
            chk("irq_set_wins", irq, 32'd1);
            peek(STAT); chk("stat_irq", readdata, 32'h6);
        end else begin
            for (int i = 0; i < 100; i++) step(1'b0, CYC, 32'd0, 1'b0);
            peek(CYC); chk("notimer_cyc", readdata, 32'd0);
            step(1'b1, CMP, 32'd55, 1'b0);
            peek(CMP); chk("notimer_cmp", readdata, 32'd0);
            step(1'b1, STAT, 32'h4, 1'b0);
            peek(STAT); chk("notimer_stat", readdata, 32'h2);
        end

        // reset mid-drain
        step(1'b1, 32'h10, 32'h5A5A_5A5A, 1'b0);
        step(1'b1, PUSH, 32'h31, 1'b0);
        step(1'b1, PUSH, 32'h32, 1'b0);
        step(1'b1, PUSH, 32'h33, 1'b0);
        if (TEN) wait_cyc(32'd57);
        chk("pre_rst_valid", dbg_valid, 32'd1);
        dbg_ready = 1'b1; addr = CYC;
        #1 reset = 1'b1;
        #1 chk("mid_rst_valid", dbg_valid, 32'd0);
        chk("mid_rst_data", dbg_data, 32'd0);
        chk("mid_rst_irq", irq, 32'd0);
        peek(CYC);   chk("mid_rst_cyc", readdata, 32'd0);
        peek(CMP);   chk("mid_rst_cmp", readdata, TEN ? 32'hFFFF_FFFF : 32'd0);
        peek(32'h10); chk("mid_rst_ram", readdata, 32'h5A5A_5A5A);
        @(posedge clk); #1 reset = 1'b0;
        step(1'b0, CYC, 32'd0, 1'b0);
        peek(CYC); chk("post_rst_cyc", readdata, TEN ? 32'd1 : 32'd0);
        step(1'b0, CYC, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
